// File: rtl/stopwatch_counter_if.sv
// stopwatch_counter_if: control inputs and display/status outputs of the stopwatch engine
//   run, lap, clear            : asynchronous switch/button levels into the engine
//   digit0..digit3, dp_n       : BCD digits and active-low decimal-point mask
//   holding, tick, wrap        : lap-freeze flag, count pulse, rollover pulse
interface stopwatch_counter_if;
  logic run;
  logic lap;
  logic clear;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] dp_n;
  logic holding;
  logic tick;
  logic wrap;
  modport master (
    output run, lap, clear,
    input digit0, digit1, digit2, digit3, dp_n, holding, tick, wrap
  );
  modport slave (
    input run, lap, clear,
    output digit0, digit1, digit2, digit3, dp_n, holding, tick, wrap
  );
endinterface

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: M:SS.t BCD stopwatch engine with run/stop, lap freeze and clear
//   clk   : system clock, rising edge
//   reset : asynchronous active-high, clears all state
//   bus   : slave side of stopwatch_counter_if (run/lap/clear in, digits/dp_n/holding/tick/wrap out)
module stopwatch_counter #(
  parameter int CLK_HZ = 100_000_000,
  parameter int TICK_HZ = 10,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic reset,
  stopwatch_counter_if.slave bus
);
  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  typedef enum logic [1:0] {STOPPED, RUNNING, LAP} state_t;
  state_t state, state_next;
  logic [SYNC_STAGES-1:0] run_q, lap_q, clear_q;
  logic lap_d, run_s, lap_s, clear_s, lap_rise;
  logic [PW-1:0] pre;
  logic [15:0] cnt, lap_r, nxt;
  logic active, inc, zero, k1, k2, k3, wrap_now, tick_r, wrap_r;
  assign run_s = run_q[SYNC_STAGES-1];
  assign lap_s = lap_q[SYNC_STAGES-1];
  assign clear_s = clear_q[SYNC_STAGES-1];
  assign lap_rise = lap_s & ~lap_d;
  assign active = state != STOPPED;
  assign inc = active && pre == PMAX;
  assign zero = state == STOPPED && clear_s;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q <= '0;
      lap_q <= '0;
      clear_q <= '0;
      lap_d <= 1'b0;
    end else begin
      run_q <= {run_q[SYNC_STAGES-2:0], bus.run};
      lap_q <= {lap_q[SYNC_STAGES-2:0], bus.lap};
      clear_q <= {clear_q[SYNC_STAGES-2:0], bus.clear};
      lap_d <= lap_s;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= STOPPED;
    else state <= state_next;
  end
  // Dropping run outranks a simultaneous lap edge.
  always_comb begin
    state_next = !run_s ? STOPPED :
                 state == STOPPED ? RUNNING :
                 lap_rise ? (state == RUNNING ? LAP : RUNNING) : state;
  end
  // Ripple carry across the BCD digits; digit2 rolls at 5 for seconds tens.
  always_comb begin
    k1 = cnt[3:0] == 4'd9;
    k2 = k1 && cnt[7:4] == 4'd9;
    k3 = k2 && cnt[11:8] == 4'd5;
    wrap_now = k3 && cnt[15:12] == 4'd9;
    nxt[3:0] = k1 ? 4'd0 : cnt[3:0] + 4'd1;
    nxt[7:4] = !k1 ? cnt[7:4] : k2 ? 4'd0 : cnt[7:4] + 4'd1;
    nxt[11:8] = !k2 ? cnt[11:8] : k3 ? 4'd0 : cnt[11:8] + 4'd1;
    nxt[15:12] = !k3 ? cnt[15:12] : wrap_now ? 4'd0 : cnt[15:12] + 4'd1;
  end
  // Prescaler only advances while counting, so a pause resumes mid-interval.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
      cnt <= '0;
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
    end else begin
      tick_r <= inc;
      wrap_r <= inc && wrap_now;
      if (zero) begin
        pre <= '0;
        cnt <= '0;
      end else if (active) begin
        pre <= inc ? '0 : pre + 1'b1;
        if (inc) cnt <= nxt;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lap_r <= '0;
    else if (state_next == LAP && state != LAP) lap_r <= cnt;
  end
  always_comb begin
    {bus.digit3, bus.digit2, bus.digit1, bus.digit0} = state == LAP ? lap_r : cnt;
    bus.holding = state == LAP;
  end
  assign bus.tick = tick_r;
  assign bus.wrap = wrap_r;
  assign bus.dp_n = 4'b1101;
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: directed vector bench for stopwatch_counter at PRESCALE = 10
module tb_stopwatch_counter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  stopwatch_counter_if bus();
  stopwatch_counter #(.CLK_HZ(100), .TICK_HZ(10), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic run;
    logic lap;
    logic clear;
    int cycles;
    logic [15:0] digits;
    logic holding;
  } vec_t;
  vec_t vecs[13];
  function automatic logic [15:0] shown();
    return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
  endfunction
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 132, 16'h0023, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 3, 16'h0023, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 20, 16'h0023, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 157, 16'h0023, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 3, 16'h0041, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 2, 16'h0041, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 5, 16'h0042, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 3, 16'h0042, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 10, 16'h0042, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 3, 16'h0000, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 5, 16'h0000, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 12, 16'h0000, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1, 16'h0001, 1'b0};
    bus.run = 1'b0;
    bus.lap = 1'b0;
    bus.clear = 1'b0;
    step(3);
    chk("reset digits", 32'(shown()), 32'h0000);
    chk("reset holding", 32'(bus.holding), 32'd0);
    chk("reset tick", 32'(bus.tick), 32'd0);
    chk("reset wrap", 32'(bus.wrap), 32'd0);
    chk("reset dp_n", 32'(bus.dp_n), 32'hd);
    reset = 1'b0;
    bus.run = 1'b1;
    step(12);
    chk("first tick early", 32'(bus.tick), 32'd0);
    chk("pre first tick digits", 32'(shown()), 32'h0000);
    step(1);
    chk("first tick", 32'(bus.tick), 32'd1);
    chk("first tick digits", 32'(shown()), 32'h0001);
    step(1);
    chk("tick one cycle", 32'(bus.tick), 32'd0);
    step(89);
    chk("tenth tick", 32'(bus.tick), 32'd1);
    chk("one second", 32'(shown()), 32'h0010);
    for (int i = 0; i < 13; i++) begin
      bus.run = vecs[i].run;
      bus.lap = vecs[i].lap;
      bus.clear = vecs[i].clear;
      step(vecs[i].cycles);
      chk($sformatf("vec%0d digits", i), 32'(shown()), 32'(vecs[i].digits));
      chk($sformatf("vec%0d holding", i), 32'(bus.holding), 32'(vecs[i].holding));
    end
    step(60);
    chk("pause start", 32'(shown()), 32'h0007);
    step(2);
    bus.run = 1'b0;
    step(50);
    chk("paused hold", 32'(shown()), 32'h0007);
    bus.run = 1'b1;
    step(7);
    chk("resume early tick", 32'(bus.tick), 32'd0);
    chk("resume early digits", 32'(shown()), 32'h0007);
    step(1);
    chk("resume partial tick", 32'(bus.tick), 32'd1);
    chk("resume digits", 32'(shown()), 32'h0008);
    reset = 1'b1;
    bus.run = 1'b0;
    step(2);
    reset = 1'b0;
    bus.run = 1'b1;
    step(59993);
    chk("max digits", 32'(shown()), 32'h9599);
    chk("max no wrap", 32'(bus.wrap), 32'd0);
    step(9);
    chk("max hold", 32'(shown()), 32'h9599);
    chk("pre wrap tick", 32'(bus.tick), 32'd0);
    step(1);
    chk("wrap digits", 32'(shown()), 32'h0000);
    chk("wrap pulse", 32'(bus.wrap), 32'd1);
    chk("wrap tick", 32'(bus.tick), 32'd1);
    step(1);
    chk("wrap one cycle", 32'(bus.wrap), 32'd0);
    chk("wrap tick one cycle", 32'(bus.tick), 32'd0);
    bus.run = 1'b0;
    bus.lap = 1'b1;
    step(3);
    chk("run fall beats lap", 32'(bus.holding), 32'd0);
    step(20);
    chk("stopped after tie", 32'(bus.holding), 32'd0);
    chk("stopped digits", 32'(shown()), 32'h0000);
    bus.lap = 1'b0;
    bus.run = 1'b1;
    step(29);
    chk("mid count tick", 32'(bus.tick), 32'd1);
    chk("mid count digits", 32'(shown()), 32'h0003);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset digits", 32'(shown()), 32'h0000);
    chk("async reset tick", 32'(bus.tick), 32'd0);
    chk("async reset holding", 32'(bus.holding), 32'd0);
    chk("async reset dp_n", 32'(bus.dp_n), 32'hd);
    step(2);
    reset = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
